code_digit_serializer: RTL
==========================

Name: code_digit_serializer

Overview:
- Parallel-in, digit-out counterpart of the keypad entry shift register in the lock datapath.
- Captures a complete stored code word (DIGITS x WIDTH bits, oldest-entered digit in the least significant slot).
- Replays the code one digit at a time over a valid/ready handshake, in original entry order.
- Consumers are the display scanner, the code comparator and the debug UART formatter.

Parameters:
- WIDTH, 4, bits per digit.
- DIGITS, 4, digits per code word; the code word is DIGITS*WIDTH bits, 16 by default.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- clr  input  1  asynchronous, active-low reset; clr=0 forces reset state immediately, released synchronously by the surrounding design.
- load  input  1  capture request; sampled only in IDLE.
- data_i  input  DIGITS*WIDTH  code word; digit k is data_i[k*WIDTH +: WIDTH], digit 0 is the oldest.
- digit_o  output  WIDTH  current digit.
- digit_valid  output  1  digit_o holds a valid digit.
- digit_ready  input  1  consumer accepts the digit; a transfer occurs when digit_valid & digit_ready at a rising edge.
- last  output  1  high with digit_valid when digit_o is digit DIGITS-1.
- busy  output  1  high in SEND and DONE states.
- done  output  1  one-cycle pulse after the final transfer.

Behaviour:
- Reset (clr=0, asynchronous): state=IDLE, internal shift register=0, index=0, digit_o=0, digit_valid=0, last=0, busy=0, done=0.
- States: IDLE, SEND, DONE.
- IDLE:
  - load=1 at an edge: capture data_i into the shift register, set index=0, go to SEND.
  - One-cycle latency: digit_valid=1 and digit_o=data_i[WIDTH-1:0] in the cycle following the load edge.
- SEND:
  - digit_o is always the low WIDTH bits of the shift register; digit_valid=1.
  - On a transfer: shift the register right by WIDTH with zero fill, index+1.
  - If the transferred digit was index DIGITS-1: go to DONE and drop digit_valid at that edge.
  - No transfer (digit_ready=0): digit_o, index and last are held stable; digit_valid is never withdrawn.
  - last = (index == DIGITS-1).
- DONE:
  - Lasts exactly one cycle with done=1; then IDLE.
  - done=1 and digit_valid=1 never occur together.
- load is ignored in SEND and DONE. A new capture is possible the first IDLE cycle after DONE.
- Minimum period between load pulses with digit_ready held at 1: DIGITS+2 cycles.
- data_i changes after the capture edge have no effect on the digits being sent.
- Reset mid-SEND aborts immediately with no done pulse. The next load restarts from digit 0.
- digit_ready while digit_valid=0 has no effect.
- The index counter is $clog2(DIGITS) bits wide and never wraps inside SEND.

Optional Feature:
- Macro DIGIT_CHECK_EN.
- When defined:
  - Adds output bad_digit (1 bit): high in DONE when any digit of the captured word was > 9, i.e. not a valid keypad digit. The flag is evaluated per digit as it is transferred and accumulated.
  - The flag clears on reset or on the next load.
  - With WIDTH<4, bad_digit ties to 0.
- When undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset then load with data_i=16'h4321, digit_ready=1:
  - digit_o sequence 1,2,3,4 on consecutive cycles; last only with 4; done pulses the next cycle.
  - busy high for 5 cycles.
- Backpressure with data_i=16'h9807:
  - Hold digit_ready=0 for 3 cycles after the first valid: digit_o stays 7 and digit_valid stays 1.
  - Then toggle digit_ready 1/0: sequence 7,0,8,9 with no digit lost or duplicated.
- load pulsed again mid-SEND with a different data_i: ignored, and the original digits complete.
- Load issued in the IDLE cycle right after done: accepted, with the new first digit valid one cycle later.
- clr asserted between the 2nd and 3rd transfer:
  - All outputs 0 immediately; no done pulse.
  - A subsequent load of 16'hABCD emits D,C,B,A.
- With DIGIT_CHECK_EN defined:
  - data_i=16'h12A4 gives bad_digit=1 in DONE.
  - data_i=16'h1234 gives bad_digit=0.
  - After a reset, bad_digit reads 0.

Source files
------------

// File: rtl/code_digit_serializer.sv
`default_nettype none
// ============================================================================
// Module  : code_digit_serializer
// Purpose : Captures a DIGITS x WIDTH code word and replays it one digit at a
//           time (oldest first) over a valid/ready handshake.
// Option  : define DIGIT_CHECK_EN to add the bad_digit (> 9) output.
// Rev     : 1.0 - initial release
// ============================================================================
module code_digit_serializer #(
  parameter int WIDTH  = 4,
  parameter int DIGITS = 4
) (
  input  logic                    clk,
  input  logic                    clr,
  input  logic                    load,
  input  logic [DIGITS*WIDTH-1:0] data_i,
  output logic [WIDTH-1:0]        digit_o,
  output logic                    digit_valid,
  input  logic                    digit_ready,
  output logic                    last,
  output logic                    busy,
  output logic                    done
`ifdef DIGIT_CHECK_EN
  ,
  output logic                    bad_digit
`endif
);

  localparam int c_WORD_W = DIGITS * WIDTH;
  localparam int c_IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(DIGITS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_next_state;
  logic [c_WORD_W-1:0]  r_shift;
  logic [c_IDX_W-1:0]   r_index;
  logic                 w_capture;
  logic                 w_xfer;
  logic                 w_last_idx;

  assign w_capture  = (r_state == S_IDLE) && load;
  assign w_xfer     = (r_state == S_SEND) && digit_ready;
  assign w_last_idx = (r_index == c_LAST_IDX);

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: if (load) w_next_state = S_SEND;
      S_SEND: if (w_xfer && w_last_idx) w_next_state = S_DONE;
      S_DONE: w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // Zero fill leaves the register empty after the last digit, so digit_o idles at 0.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_shift <= '0;
      r_index <= '0;
    end else if (w_capture) begin
      r_shift <= data_i;
      r_index <= '0;
    end else if (w_xfer) begin
      r_shift <= r_shift >> WIDTH;
      r_index <= w_last_idx ? r_index : r_index + c_IDX_W'(1);
    end
  end

  assign digit_o     = r_shift[WIDTH-1:0];
  assign digit_valid = (r_state == S_SEND);
  assign last        = (r_state == S_SEND) && w_last_idx;
  assign busy        = (r_state == S_SEND) || (r_state == S_DONE);
  assign done        = (r_state == S_DONE);

`ifdef DIGIT_CHECK_EN
  logic r_bad;
  logic w_digit_bad;

  generate
    if (WIDTH >= 4) begin : g_digit_check
      assign w_digit_bad = (r_shift[WIDTH-1:0] > WIDTH'(9));
    end else begin : g_no_digit_check
      assign w_digit_bad = 1'b0;
    end
  endgenerate

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_bad <= 1'b0;
    end else if (w_capture) begin
      r_bad <= 1'b0;
    end else if (w_xfer && w_digit_bad) begin
      r_bad <= 1'b1;
    end
  end

  assign bad_digit = (r_state == S_DONE) && r_bad;
`endif

endmodule
`default_nettype wire
